ci_unit_arbiter: RTL and testbench

Shares one custom-instruction datapath unit (three DATA_W operands in, one DATA_W result out, fixed latency) between N_REQ requesters. It arbitrates round-robin and presents the granted operands to the unit, pulsing `run` and holding `running` for the operation. After the fixed unit latency it captures the result into a per-requester response register with a valid/ready handshake. It sits between the requesting engines and the shared unit; only one operation is in flight at a time.

---
 rtl/ci_unit_arbiter.sv | 140 ++++++++++++++
 tb/tb_ci_unit_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ci_unit_arbiter.sv
// Round-robin arbiter sharing one fixed-latency custom-instruction unit among
// N_REQ requesters, with a per-requester result register and valid/ready return.
module ci_unit_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*DATA_W-1:0]  req_in0,
  input  logic [N_REQ*DATA_W-1:0]  req_in1,
  input  logic [N_REQ*DATA_W-1:0]  req_in2,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [N_REQ*DATA_W-1:0]  rsp_data,
  output logic                     unit_run,
  output logic                     unit_running,
  output logic [DATA_W-1:0]        unit_in0,
  output logic [DATA_W-1:0]        unit_in1,
  output logic [DATA_W-1:0]        unit_in2,
  input  logic [DATA_W-1:0]        unit_out0,
  output logic                     busy
);

  localparam int unsigned PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [PTR_W-1:0]         gnt_q, gnt_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     run_q, run_d;
  logic [DATA_W-1:0]        in0_q, in0_d, in1_q, in1_d, in2_q, in2_d;
  logic [N_REQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [N_REQ*DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic [N_REQ-1:0]         eligible;
  logic                     sel_found;
  logic [PTR_W-1:0]         sel_idx;
  int unsigned              cand;

  // A slot holding an unconsumed result may not issue again.
  assign eligible = req_valid & ~rsp_valid_q;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!sel_found && eligible[PTR_W'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && sel_found) req_ready[sel_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    run_d       = 1'b0;
    in0_d       = in0_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          in0_d   = req_in0[sel_idx*DATA_W +: DATA_W];
          in1_d   = req_in1[sel_idx*DATA_W +: DATA_W];
          in2_d   = req_in2[sel_idx*DATA_W +: DATA_W];
          gnt_d   = sel_idx;
          cnt_d   = CNT_INIT;
          ptr_d   = (sel_idx == PTR_W'(N_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
          run_d   = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d[gnt_q*DATA_W +: DATA_W] = unit_out0;
          rsp_valid_d[gnt_q]                 = 1'b1;
          state_d                            = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      in0_q       <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign unit_run     = run_q;
  assign unit_running = (state_q == EXEC);
  assign busy         = (state_q != IDLE);
  assign unit_in0     = in0_q;
  assign unit_in1     = in1_q;
  assign unit_in2     = in2_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_ci_unit_arbiter.sv
// Directed bench for ci_unit_arbiter: one instance at LATENCY=0, one at LATENCY=3,
// each with a summing unit model that only drives a valid result at the right age.
module tb_ci_unit_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req_valid, rsp_ready;
  logic [NR*DW-1:0] req_in0, req_in1, req_in2;

  logic [NR-1:0]    ready0, rspv0, ready3, rspv3;
  logic [NR*DW-1:0] rdata0, rdata3;
  logic             run0, running0, busy0, run3, running3, busy3;
  logic [DW-1:0]    ui0_0, ui1_0, ui2_0, uo_0, ui0_3, ui1_3, ui2_3, uo_3;
  logic [7:0]       age0_q = 8'hFF;
  logic [7:0]       age3_q = 8'hFF;

  always #5 clk = ~clk;

  ci_unit_arbiter #(.DATA_W(DW), .N_REQ(NR), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
    .req_in0(req_in0), .req_in1(req_in1), .req_in2(req_in2),
    .rsp_valid(rspv0), .rsp_ready(rsp_ready), .rsp_data(rdata0),
    .unit_run(run0), .unit_running(running0),
    .unit_in0(ui0_0), .unit_in1(ui1_0), .unit_in2(ui2_0),
    .unit_out0(uo_0), .busy(busy0)
  );

  ci_unit_arbiter #(.DATA_W(DW), .N_REQ(NR), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready3),
    .req_in0(req_in0), .req_in1(req_in1), .req_in2(req_in2),
    .rsp_valid(rspv3), .rsp_ready(rsp_ready), .rsp_data(rdata3),
    .unit_run(run3), .unit_running(running3),
    .unit_in0(ui0_3), .unit_in1(ui1_3), .unit_in2(ui2_3),
    .unit_out0(uo_3), .busy(busy3)
  );

  // Unit model: result is only correct exactly LATENCY cycles after the run pulse.
  always @(posedge clk) begin
    age0_q <= run0 ? 8'd1 : ((age0_q == 8'hFF) ? age0_q : age0_q + 8'd1);
    age3_q <= run3 ? 8'd1 : ((age3_q == 8'hFF) ? age3_q : age3_q + 8'd1);
  end
  assign uo_0 = (((run0 ? 8'd0 : age0_q)) == 8'd0) ? ui0_0 + ui1_0 + ui2_0 : 32'hDEADBEEF;
  assign uo_3 = (((run3 ? 8'd0 : age3_q)) == 8'd3) ? ui0_3 + ui1_3 + ui2_3 : 32'hDEADBEEF;

  typedef struct {
    logic       rst;
    logic [3:0] rv, rr, ready, rspv;
    logic       busy, run;
    int         g;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic row(input logic r, input logic [3:0] rv, rr, ready, rspv,
                     input logic b, input logic ru, input int g);
    vec_t v;
    v.rst = r; v.rv = rv; v.rr = rr; v.ready = ready; v.rspv = rspv;
    v.busy = b; v.run = ru; v.g = g;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] slot_sum(input int s);
    return 32'(6 * (s + 1));
  endfunction

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    for (int s = 0; s < NR; s++) begin
      req_in0[s*DW +: DW] = 32'(s + 1);
      req_in1[s*DW +: DW] = 32'(2 * (s + 1));
      req_in2[s*DW +: DW] = 32'(3 * (s + 1));
    end

    // LATENCY=0: single op, all-slot round robin, then slot 2 withholds rsp_ready.
    row(1, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 0, 0, -1);
    row(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1, 1,  0);
    row(0, 4'b1111, 4'b1111, 4'b0010, 4'b0001, 0, 0, -1);
    row(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1, 1,  1);
    row(0, 4'b1111, 4'b1111, 4'b0100, 4'b0010, 0, 0, -1);
    row(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1, 1,  2);
    row(0, 4'b1111, 4'b1111, 4'b1000, 4'b0100, 0, 0, -1);
    row(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1, 1,  3);
    row(0, 4'b1111, 4'b1111, 4'b0001, 4'b1000, 0, 0, -1);
    row(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1, 1,  0);
    row(0, 4'b1111, 4'b1111, 4'b0010, 4'b0001, 0, 0, -1);
    row(0, 4'b1111, 4'b1011, 4'b0000, 4'b0000, 1, 1,  1);
    row(0, 4'b1111, 4'b1011, 4'b0100, 4'b0010, 0, 0, -1);
    row(0, 4'b1111, 4'b1011, 4'b0000, 4'b0000, 1, 1,  2);
    row(0, 4'b1111, 4'b1011, 4'b1000, 4'b0100, 0, 0, -1);
    row(0, 4'b1111, 4'b1011, 4'b0000, 4'b0100, 1, 1,  3);
    row(0, 4'b1111, 4'b1011, 4'b0001, 4'b1100, 0, 0, -1);
    row(0, 4'b1111, 4'b1011, 4'b0000, 4'b0100, 1, 1,  0);
    row(0, 4'b1111, 4'b1011, 4'b0010, 4'b0101, 0, 0, -1);
    row(0, 4'b1111, 4'b1011, 4'b0000, 4'b0100, 1, 1,  1);
    row(0, 4'b1111, 4'b1011, 4'b1000, 4'b0110, 0, 0, -1);
    row(0, 4'b1111, 4'b1011, 4'b0000, 4'b0100, 1, 1,  3);
    row(0, 4'b1111, 4'b1111, 4'b0001, 4'b1100, 0, 0, -1);
    row(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1, 1,  0);
    row(0, 4'b1111, 4'b1111, 4'b0010, 4'b0001, 0, 0, -1);
    row(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1, 1,  1);
    row(0, 4'b1111, 4'b1111, 4'b0100, 4'b0010, 0, 0, -1);
    row(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1, 1,  2);
    // Lone requester on slot 3: pointer wraps, then slot 0 joins and wins.
    row(1, 4'b1000, 4'b1111, 4'b1000, 4'b0000, 0, 0, -1);
    row(0, 4'b1000, 4'b1111, 4'b0000, 4'b0000, 1, 1,  3);
    row(0, 4'b1000, 4'b1111, 4'b0000, 4'b1000, 0, 0, -1);
    row(0, 4'b1000, 4'b1111, 4'b1000, 4'b0000, 0, 0, -1);
    row(0, 4'b1000, 4'b1111, 4'b0000, 4'b0000, 1, 1,  3);
    row(0, 4'b1000, 4'b1111, 4'b0000, 4'b1000, 0, 0, -1);
    row(0, 4'b1001, 4'b1111, 4'b0001, 4'b0000, 0, 0, -1);
    row(0, 4'b1001, 4'b1111, 4'b0000, 4'b0000, 1, 1,  0);
    row(0, 4'b1001, 4'b1111, 4'b1000, 4'b0001, 0, 0, -1);

    #3;
    chk("reset busy", 32'(busy0), 0);
    chk("reset running", 32'(running0), 0);
    chk("reset run", 32'(run0), 0);
    chk("reset rsp_valid", 32'(rspv0), 0);
    chk("reset rsp_data", rdata0[31:0] | rdata0[127:96], 0);
    chk("reset unit_in0", ui0_0, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) pulse_reset();
      req_valid = tbl[i].rv;
      rsp_ready = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("row%0d req_ready", i), 32'(ready0), 32'(tbl[i].ready));
      chk($sformatf("row%0d rsp_valid", i), 32'(rspv0), 32'(tbl[i].rspv));
      chk($sformatf("row%0d busy", i), 32'(busy0), 32'(tbl[i].busy));
      chk($sformatf("row%0d running", i), 32'(running0), 32'(tbl[i].busy));
      chk($sformatf("row%0d unit_run", i), 32'(run0), 32'(tbl[i].run));
      for (int s = 0; s < NR; s++)
        if (tbl[i].rspv[s])
          chk($sformatf("row%0d rsp_data%0d", i, s), rdata0[s*DW +: DW], slot_sum(s));
      if (tbl[i].g >= 0) begin
        chk($sformatf("row%0d unit_in0", i), ui0_0, 32'(tbl[i].g + 1));
        chk($sformatf("row%0d unit_in1", i), ui1_0, 32'(2 * (tbl[i].g + 1)));
        chk($sformatf("row%0d unit_in2", i), ui2_0, 32'(3 * (tbl[i].g + 1)));
      end
      @(posedge clk); #1;
    end

    // LATENCY=3 with wrapping operands.
    req_in0[31:0] = 32'hFFFFFFFF;
    req_in1[31:0] = 32'd1;
    req_in2[31:0] = 32'd1;
    pulse_reset();
    req_valid = 4'b0001;
    rsp_ready = 4'b1111;
    @(negedge clk);
    chk("lat3 grant", 32'(ready3), 32'b0001);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("lat3 c%0d running", k), 32'(running3), 32'(k <= 4));
      chk($sformatf("lat3 c%0d run", k), 32'(run3), 32'(k == 1));
      chk($sformatf("lat3 c%0d rsp_valid", k), 32'(rspv3), (k == 5) ? 32'b0001 : 32'b0);
      if (k == 1) chk("lat3 unit_in0", ui0_3, 32'hFFFFFFFF);
    end
    chk("lat3 rsp_data", rdata3[31:0], 32'h00000001);
    chk("lat3 operands held", ui0_3, 32'hFFFFFFFF);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #1;
    pulse_reset();
    req_valid = 4'b1000;
    rsp_ready = 4'b1111;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #2;
    chk("pre-reset busy", 32'(busy3), 1);
    rst = 1'b0;
    #1;
    chk("async busy", 32'(busy3), 0);
    chk("async running", 32'(running3), 0);
    chk("async unit_in0", ui0_3, 0);
    chk("async unit_in2", ui2_3, 0);
    chk("async dut0 rsp_data3", rdata0[3*DW +: DW], 0);
    req_valid = 4'b1100;
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post-reset grant", 32'(ready3), 32'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
